// File: rtl/yaya_pkg.sv
// Shared types for the pedestrian countdown: controller states, display digit codes
// and the 7-segment patterns (bit0 = a ... bit6 = g, active-high).
package yaya_pkg;

  typedef enum logic [2:0] {
    BEKLE   = 3'd0,
    KIRMIZI = 3'd1,
    MAVI    = 3'd2,
    YESIL   = 3'd3,
    HATA    = 3'd4
  } durum_t;

  // 0-9 are plain BCD; the two spare codes select blank and dash.
  typedef logic [3:0] bcd_t;
  localparam bcd_t KOD_BOS  = 4'd10;
  localparam bcd_t KOD_TIRE = 4'd11;

  localparam logic [6:0] SEG_BOS  = 7'h00;
  localparam logic [6:0] SEG_TIRE = 7'h40;

  // Index 0 is the rightmost element.
  localparam logic [9:0][6:0] SEG_RAKAM = {
    7'h6F, 7'h7F, 7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };

endpackage

// File: rtl/yaya_geri_sayim_if.sv
// Signal bundle between the vehicle light controller side and the pedestrian
// countdown block: lamp inputs one way, pedestrian lamps and display the other.
interface yaya_geri_sayim_if;
  logic       kirmizi_led;
  logic       mavi_led;
  logic       yesil_led;
  logic       yaya_yesil;
  logic       yaya_kirmizi;
  logic [6:0] seg;
  logic [1:0] an;
  logic       hata;

  // Lamps are level signals sampled every clock; no valid/ready pairing is used.
  modport master (
    output kirmizi_led, mavi_led, yesil_led,
    input  yaya_yesil, yaya_kirmizi, seg, an, hata
  );

  modport slave (
    input  kirmizi_led, mavi_led, yesil_led,
    output yaya_yesil, yaya_kirmizi, seg, an, hata
  );
endinterface

// File: rtl/yedi_segment_kodlayici.sv
// Combinational decoder from a display code (BCD digit, blank or dash) to
// active-high 7-segment pattern.
module yedi_segment_kodlayici
  import yaya_pkg::*;
(
  input  bcd_t       kod,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BOS;
    if (kod == KOD_TIRE) begin
      seg = SEG_TIRE;
    end else if (kod <= 4'd9) begin
      seg = SEG_RAKAM[kod];
    end
  end

endmodule

// File: rtl/yaya_geri_sayim.sv
// Pedestrian countdown: follows the vehicle lamp phase, counts the phase's seconds
// down on a 2-digit multiplexed display and drives the walk/don't-walk lamps.
module yaya_geri_sayim
  import yaya_pkg::*;
#(
  parameter int CLK_HZ       = 100_000_000,
  parameter int KIRMIZI_TIME = 10,
  parameter int MAVI_TIME    = 2,
  parameter int YESIL_TIME   = 5,
  parameter int TARAMA_HZ    = 1000,
  parameter int YANIP_SN     = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       kirmizi_led,
  input  logic       mavi_led,
  input  logic       yesil_led,
  output logic       yaya_yesil,
  output logic       yaya_kirmizi,
  output logic [6:0] seg,
  output logic [1:0] an,
  output logic       hata
);

  localparam int PW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [PW-1:0] PRESC_SON  = PW'(CLK_HZ - 1);
  localparam logic [PW-1:0] PRESC_YARI = PW'(CLK_HZ / 2);
  localparam int TARAMA_BOL = (CLK_HZ / (2 * TARAMA_HZ) > 1) ? CLK_HZ / (2 * TARAMA_HZ) : 1;
  localparam int TW = (TARAMA_BOL > 1) ? $clog2(TARAMA_BOL) : 1;
  localparam logic [TW-1:0] TARAMA_SON = TW'(TARAMA_BOL - 1);

  logic [2:0]    lamba;
  logic          gecersiz_onceki;
  durum_t        durum, durum_n, faz;
  logic          gecerli;
  logic [6:0]    kalan, kalan_n;
  logic [PW-1:0] presc, presc_n;
  logic          sarma;
  logic [TW-1:0] tarama;
  logic          hane;
  bcd_t          onlar, birler, hane_kod;
  logic [6:0]    seg_d;
  logic          yesil_d;

  function automatic logic [6:0] faz_suresi(input durum_t f);
    case (f)
      KIRMIZI: faz_suresi = 7'(KIRMIZI_TIME);
      MAVI:    faz_suresi = 7'(MAVI_TIME);
      YESIL:   faz_suresi = 7'(YESIL_TIME);
      default: faz_suresi = 7'd0;
    endcase
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lamba           <= 3'b000;
      gecersiz_onceki <= 1'b0;
    end else begin
      lamba           <= {kirmizi_led, mavi_led, yesil_led};
      gecersiz_onceki <= !gecerli;
    end
  end

  always_comb begin
    faz     = BEKLE;
    gecerli = 1'b1;
    case (lamba)
      3'b100:  faz = KIRMIZI;
      3'b010:  faz = MAVI;
      3'b001:  faz = YESIL;
      default: gecerli = 1'b0;
    endcase
  end

  assign sarma = (presc == PRESC_SON);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      durum <= BEKLE;
      kalan <= 7'd0;
      presc <= '0;
    end else begin
      durum <= durum_n;
      kalan <= kalan_n;
      presc <= presc_n;
    end
  end

  // A phase change takes priority over a coincident prescaler wrap.
  always_comb begin
    durum_n = durum;
    kalan_n = kalan;
    presc_n = presc;
    case (durum)
      BEKLE: begin
        if (gecerli) begin
          durum_n = faz;
          kalan_n = faz_suresi(faz);
          presc_n = '0;
        end
      end
      KIRMIZI, MAVI, YESIL: begin
        presc_n = sarma ? '0 : presc + 1'b1;
        if (!gecerli && gecersiz_onceki) begin
          durum_n = HATA;
        end else if (gecerli && faz != durum) begin
          durum_n = faz;
          kalan_n = faz_suresi(faz);
          presc_n = '0;
        end else if (sarma) begin
          if (kalan == 7'd0) durum_n = HATA;
          else kalan_n = kalan - 7'd1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tarama <= '0;
      hane   <= 1'b0;
    end else if (tarama == TARAMA_SON) begin
      tarama <= '0;
      hane   <= !hane;
    end else begin
      tarama <= tarama + 1'b1;
    end
  end

  assign onlar  = 4'(kalan / 7'd10);
  assign birler = 4'(kalan % 7'd10);

  // hane = 1 selects the tens digit.
  always_comb begin
    hane_kod = KOD_BOS;
    case (durum)
      BEKLE: hane_kod = KOD_BOS;
      HATA:  hane_kod = KOD_TIRE;
      default: begin
        if (hane) hane_kod = (onlar == 4'd0) ? KOD_BOS : onlar;
        else hane_kod = birler;
      end
    endcase
  end

  yedi_segment_kodlayici u_kodlayici (
    .kod (hane_kod),
    .seg (seg_d)
  );

  assign yesil_d = (durum == KIRMIZI) && ((kalan > 7'(YANIP_SN)) || (presc < PRESC_YARI));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      yaya_yesil   <= 1'b0;
      yaya_kirmizi <= 1'b1;
      hata         <= 1'b0;
      seg          <= 7'h00;
      an           <= 2'b11;
    end else begin
      yaya_yesil   <= yesil_d;
      yaya_kirmizi <= !yesil_d;
      hata         <= (durum == HATA);
      seg          <= seg_d;
      an           <= hane ? 2'b01 : 2'b10;
    end
  end

endmodule

// File: tb/tb_yaya_geri_sayim.sv
// Bench for yaya_geri_sayim: directed phase sequences plus random lamp traffic,
// checked cycle by cycle against a time-since-phase-entry reference model.
module tb_yaya_geri_sayim;

  localparam int CLK_HZ     = 10;
  localparam int TARAMA_HZ  = 1;
  localparam int YANIP      = 3;
  localparam int TARAMA_BOL = CLK_HZ / (2 * TARAMA_HZ);
  localparam logic [11:0] RESET_VEC = {1'b0, 1'b0, 1'b1, 2'b11, 7'h00};

  logic clk = 1'b0;
  logic rst = 1'b1;
  yaya_geri_sayim_if bus ();

  yaya_geri_sayim #(
    .CLK_HZ       (CLK_HZ),
    .KIRMIZI_TIME (10),
    .MAVI_TIME    (2),
    .YESIL_TIME   (5),
    .TARAMA_HZ    (TARAMA_HZ),
    .YANIP_SN     (YANIP)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .kirmizi_led  (bus.kirmizi_led),
    .mavi_led     (bus.mavi_led),
    .yesil_led    (bus.yesil_led),
    .yaya_yesil   (bus.yaya_yesil),
    .yaya_kirmizi (bus.yaya_kirmizi),
    .seg          (bus.seg),
    .an           (bus.an),
    .hata         (bus.hata)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  logic [11:0] exp_q[$];

  // Reference model: phase (0 idle, 1 red, 2 blue, 3 green, 4 fault),
  // cycles since phase entry, phase length in seconds.
  int         m_phase, m_t, m_T, m_ill, m_edge;
  logic [2:0] m_q;

  function automatic int pat_phase(input logic [2:0] p);
    case (p)
      3'b100:  return 1;
      3'b010:  return 2;
      3'b001:  return 3;
      default: return 0;
    endcase
  endfunction

  function automatic int sure(input int ph);
    case (ph)
      1:       return 10;
      2:       return 2;
      default: return 5;
    endcase
  endfunction

  function automatic logic [6:0] seg_of(input int d);
    case (d)
      0: return 7'h3F;  1: return 7'h06;  2: return 7'h5B;  3: return 7'h4F;
      4: return 7'h66;  5: return 7'h6D;  6: return 7'h7D;  7: return 7'h07;
      8: return 7'h7F;  default: return 7'h6F;
    endcase
  endfunction

  function automatic logic [11:0] beklenen();
    int kal, sel;
    logic yy;
    logic [6:0] s;
    kal = 0;
    if (m_phase >= 1 && m_phase <= 3) kal = m_T - m_t / CLK_HZ;
    if (kal < 0) kal = 0;
    yy  = (m_phase == 1) && (kal > YANIP || (m_t % CLK_HZ) < CLK_HZ / 2);
    sel = (m_edge / TARAMA_BOL) % 2;
    if (m_phase == 0) s = 7'h00;
    else if (m_phase == 4) s = 7'h40;
    else if (sel == 1) s = (kal / 10 == 0) ? 7'h00 : seg_of(kal / 10);
    else s = seg_of(kal % 10);
    return {m_phase == 4, yy, !yy, (sel == 1) ? 2'b01 : 2'b10, s};
  endfunction

  task automatic kontrol(input string ad, input logic [11:0] got, input logic [11:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s @%0t: got hata=%b yesil=%b kirmizi=%b an=%b seg=%h, expected hata=%b yesil=%b kirmizi=%b an=%b seg=%h",
                  ad, $time, got[11], got[10], got[9], got[8:7], got[6:0],
                  exp[11], exp[10], exp[9], exp[8:7], exp[6:0]);
  endtask

  function automatic logic [11:0] cikis();
    return {bus.hata, bus.yaya_yesil, bus.yaya_kirmizi, bus.an, bus.seg};
  endfunction

  // Scoreboard producer: expected output after this edge, then advance the model.
  always @(posedge clk) begin
    if (rst) begin
      m_phase = 0; m_t = 0; m_T = 0; m_ill = 0; m_edge = 0; m_q = 3'b000;
      exp_q.delete();
    end else begin
      int ph;
      exp_q.push_back(beklenen());
      ph = pat_phase(m_q);
      if (ph == 0) m_ill++; else m_ill = 0;
      if (m_phase == 4) begin
      end else if (m_phase != 0 && m_ill >= 2) begin
        m_phase = 4;
      end else if (ph != 0 && ph != m_phase) begin
        m_phase = ph; m_t = 0; m_T = sure(ph);
      end else if (m_phase != 0) begin
        m_t++;
        if (m_t >= (m_T + 1) * CLK_HZ) m_phase = 4;
      end
      m_q = {bus.kirmizi_led, bus.mavi_led, bus.yesil_led};
      m_edge++;
    end
  end

  // Monitor: one DUT output word per cycle, sampled on the falling edge.
  always @(negedge clk) begin
    if (rst) kontrol("reset_hold", cikis(), RESET_VEC);
    else if (exp_q.size() > 0) kontrol("cycle", cikis(), exp_q.pop_front());
  end

  task automatic pinler(input logic [2:0] p);
    {bus.kirmizi_led, bus.mavi_led, bus.yesil_led} = p;
  endtask

  task automatic lamba(input logic [2:0] p, input int n);
    pinler(p);
    repeat (n) @(negedge clk);
  endtask

  task automatic reset_darbe(input int n);
    #2 rst = 1'b1;
    #1 kontrol("async_reset", cikis(), RESET_VEC);
    repeat (n) begin
      @(negedge clk);
      pinler(3'($urandom_range(0, 7)));
    end
    @(negedge clk);
    pinler(3'b000);
    #2 rst = 1'b0;
  endtask

  task automatic rastgele_parca();
    logic [2:0] p;
    int n;
    if ($urandom_range(0, 9) < 7) begin
      case ($urandom_range(0, 2))
        0:       p = 3'b100;
        1:       p = 3'b010;
        default: p = 3'b001;
      endcase
      n = $urandom_range(1, 40);
    end else begin
      case ($urandom_range(0, 4))
        0:       p = 3'b000;
        1:       p = 3'b011;
        2:       p = 3'b101;
        3:       p = 3'b110;
        default: p = 3'b111;
      endcase
      n = ($urandom_range(0, 3) == 0) ? $urandom_range(2, 3) : 1;
    end
    lamba(p, n);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got no end, expected $finish");
    $fatal(1);
  end

  initial begin
    pinler(3'b000);
    @(negedge clk);
    repeat (8) begin
      @(negedge clk);
      pinler(3'($urandom_range(0, 7)));
    end
    @(negedge clk);
    pinler(3'b000);
    #2 rst = 1'b0;

    lamba(3'b000, 50);
    lamba(3'b100, 100);
    lamba(3'b010, 15);
    lamba(3'b110, 1);
    lamba(3'b010, 10);
    lamba(3'b110, 2);
    repeat (15) lamba(3'($urandom_range(0, 7)), 1);

    reset_darbe(3);
    lamba(3'b001, 30);
    reset_darbe(2);
    lamba(3'b001, 70);

    repeat (6) begin
      reset_darbe(2);
      repeat (12) rastgele_parca();
    end

    lamba(3'b000, 3);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
